event_collect_8: RTL and testbench
==================================

EVENT_COLLECT_8 -- requirements
Module: event_collect_8

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port event_in, input, 8 bits: level event sources; each channel's rising edge is one event.
REQ-004 SHALL have port mask_in, input, 8 bits: enable per channel; 1 = channel eligible for offer.
REQ-005 SHALL have port ack_in, input, 1 bit: consumer accepts the currently offered id.
REQ-006 SHALL have port pend_out, output, 8 bits: registered pending vector, unmasked.
REQ-007 SHALL have port any_out, output, 1 bit: combinational OR-reduction of (pend_out & mask_in); feeds the 8-way OR stage.
REQ-008 SHALL have port valid_out, output, 1 bit: registered; an offer is active.
REQ-009 SHALL have port id_out, output, 3 bits: registered; channel index of the active offer.

Function
REQ-010 SHALL keep an 8-bit prev register of sampled event_in; edge = event_in & ~prev; prev <= event_in every cycle.
REQ-011 SHALL set pend[i] on the clock edge where edge[i]=1; the bit is visible on pend_out the following cycle (1-cycle latency).
REQ-012 SHALL keep pend[i] set (sticky) until cleared by an ack; repeated edges on a set bit are not counted.
REQ-013 SHALL implement a two-state FSM, IDLE and OFFER; reset state IDLE.
REQ-014 IDLE: if (pend & mask_in) != 0, SHALL latch id_out = lowest set index, assert valid_out, go to OFFER; otherwise stay in IDLE.
REQ-015 OFFER: SHALL hold id_out and valid_out stable until ack_in=1.
REQ-016 OFFER with ack_in=1: SHALL clear pend[id_out], deassert valid_out, return to IDLE; the next offer appears no earlier than 2 cycles after the ack edge.
REQ-017 SHALL ignore ack_in in IDLE.
REQ-018 SHALL keep a committed offer active if its channel becomes masked during OFFER.
REQ-019 If an edge on channel id_out coincides with its ack, set SHALL win: pend bit stays 1, the event is re-offered later.
REQ-020 Edges on other channels during OFFER SHALL set their pend bits normally.
REQ-021 any_out SHALL follow mask_in changes combinationally within the same cycle.

Reset
REQ-022 On rst_n=0, asynchronously: pend=0, valid_out=0, id_out=0, FSM=IDLE, prev=8'hFF.
REQ-023 A channel already high when rst_n deasserts SHALL NOT generate an event until it falls and rises again.
REQ-024 Reset asserted during OFFER SHALL drop the offer immediately; no pending state is retained.

Configuration
REQ-025 Macro EVENT_COLLECT_SYNC_EN defined: event_in SHALL pass through a 2-flop synchronizer (reset 8'hFF) before edge detection, so pend latency becomes 3 cycles.
REQ-026 Macro EVENT_COLLECT_SYNC_EN undefined: event_in SHALL be sampled directly (synchronous sources only), with the 1-cycle latency of REQ-011.

Verification (macro undefined unless stated)
REQ-027 mask=FF, event_in 00->04 at cycle 5 -> pend_out=04 at cycle 6; valid_out=1, id_out=2 at cycle 7; any_out=1 from cycle 6.
REQ-028 event_in 00->A0, mask=FF -> offer id 5; ack -> pend=80; offer id 7 two cycles later; ack -> pend=00, any_out=0.
REQ-029 offer id 3 active, mask_in->00 -> valid_out stays 1, id_out=3, any_out=0; ack clears pend[3].
REQ-030 event_in[1] rises on the same edge as the ack of id 1 -> pend[1] stays 1; id 1 is re-offered.
REQ-031 event_in=FF held through rst_n release -> pend stays 00; event_in[0] falls then rises -> pend=01.
REQ-032 EVENT_COLLECT_SYNC_EN defined, event_in 00->01 at cycle 10 -> pend_out=01 at cycle 13; rst_n pulse during OFFER -> valid_out=0 asynchronously.

Source files
------------

// File: rtl/event_collect_8_if.sv
// event_collect_8_if: groups the event inputs, the offer handshake and the status outputs.
// The DUT connects through modport slave; the producer/consumer side uses modport master.
interface event_collect_8_if;
   logic [7:0] event_in;
   logic [7:0] mask_in;
   logic       ack_in;
   logic [7:0] pend_out;
   logic       any_out;
   logic       valid_out;
   logic [2:0] id_out;

   modport master (
      output event_in, mask_in, ack_in,
      input  pend_out, any_out, valid_out, id_out
   );

   modport slave (
      input  event_in, mask_in, ack_in,
      output pend_out, any_out, valid_out, id_out
   );
endinterface

// File: rtl/event_collect_8.sv
// event_collect_8: captures rising edges on 8 level event channels into sticky
// pending bits and offers the lowest-index unmasked pending channel to a consumer.
// Optional macro EVENT_COLLECT_SYNC_EN adds a 2-flop input synchronizer
// (pend latency 3 cycles instead of 1).
module event_collect_8 (
   input logic               clk,
   input logic               rst_n,
   event_collect_8_if.slave  bus
);
   localparam int unsigned N  = 8;
   localparam int unsigned IW = 3;

   typedef enum logic {ST_IDLE = 1'b0, ST_OFFER = 1'b1} state_t;

   state_t         r_state;
   logic [N-1:0]   r_prev;
   logic [N-1:0]   r_pend;
   logic           r_valid;
   logic [IW-1:0]  r_id;

   logic [N-1:0]   w_ev;
   logic [N-1:0]   w_edge;
   logic [N-1:0]   w_elig;
   logic [N-1:0]   w_clr;
   logic [IW-1:0]  w_low_id;

`ifdef EVENT_COLLECT_SYNC_EN
   logic [N-1:0]   r_sync1;
   logic [N-1:0]   r_sync2;

   // Two-flop synchronizer; resets high so held-high sources do not fire at reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 8'hFF;
         r_sync2 <= 8'hFF;
      end else begin
         r_sync1 <= bus.event_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_ev = r_sync2;
`else
   assign w_ev = bus.event_in;
`endif

   assign w_edge = w_ev & ~r_prev;
   assign w_elig = r_pend & bus.mask_in;
   assign w_clr  = ((r_state == ST_OFFER) && bus.ack_in) ? (N'(1) << r_id) : '0;

   // Lowest set index among eligible pending channels
   always_comb begin
      w_low_id = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_elig[i]) w_low_id = IW'(i);
      end
   end

   // Edge history and sticky pending bits; a new edge beats a coincident ack clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev <= 8'hFF;
         r_pend <= '0;
      end else begin
         r_prev <= w_ev;
         r_pend <= (r_pend & ~w_clr) | w_edge;
      end
   end

   // Offer FSM with registered valid/id; the offer holds regardless of later masking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
         r_id    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|w_elig) begin
                  r_id    <= w_low_id;
                  r_valid <= 1'b1;
                  r_state <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               if (bus.ack_in) begin
                  r_valid <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.pend_out  = r_pend;
   assign bus.any_out   = |w_elig;
   assign bus.valid_out = r_valid;
   assign bus.id_out    = r_id;
endmodule

// File: tb/tb_event_collect_8.sv
// tb_event_collect_8: directed self-checking bench for event_collect_8.
module tb_event_collect_8;
`ifdef EVENT_COLLECT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   event_collect_8_if bus ();

   event_collect_8 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.event_in = 8'h00;
      bus.mask_in  = 8'hFF;
      bus.ack_in   = 1'b0;
      step();
      checks++;
      if (bus.pend_out !== 8'h00) begin failures++; $display("FAIL reset_pend got=%h exp=00", bus.pend_out); end
      checks++;
      if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_out); end
      checks++;
      if (bus.id_out !== 3'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", bus.id_out); end
      checks++;
      if (bus.any_out !== 1'b0) begin failures++; $display("FAIL reset_any got=%b exp=0", bus.any_out); end
      rst_n = 1'b1;
      repeat (LAT + 2) step();
   endtask

   task automatic test_single();
      bus.event_in = 8'h04;
      repeat (LAT) step();
      checks++;
      if (bus.pend_out !== 8'h04) begin failures++; $display("FAIL single_pend got=%h exp=04", bus.pend_out); end
      checks++;
      if (bus.any_out !== 1'b1) begin failures++; $display("FAIL single_any got=%b exp=1", bus.any_out); end
      checks++;
      if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL single_valid_early got=%b exp=0", bus.valid_out); end
      step();
      checks++;
      if (bus.valid_out !== 1'b1 || bus.id_out !== 3'd2) begin
         failures++; $display("FAIL single_offer got=%b/%0d exp=1/2", bus.valid_out, bus.id_out);
      end
      bus.ack_in = 1'b1;
      step();
      bus.ack_in = 1'b0;
      checks++;
      if (bus.pend_out !== 8'h00 || bus.valid_out !== 1'b0) begin
         failures++; $display("FAIL single_ack got=%h/%b exp=00/0", bus.pend_out, bus.valid_out);
      end
      bus.event_in = 8'h00;
      repeat (LAT + 1) step();
   endtask

   task automatic test_priority();
      bus.event_in = 8'hA0;
      repeat (LAT) step();
      checks++;
      if (bus.pend_out !== 8'hA0) begin failures++; $display("FAIL prio_pend got=%h exp=a0", bus.pend_out); end
      step();
      checks++;
      if (bus.valid_out !== 1'b1 || bus.id_out !== 3'd5) begin
         failures++; $display("FAIL prio_offer5 got=%b/%0d exp=1/5", bus.valid_out, bus.id_out);
      end
      bus.ack_in = 1'b1;
      step();
      bus.ack_in = 1'b0;
      checks++;
      if (bus.pend_out !== 8'h80 || bus.valid_out !== 1'b0) begin
         failures++; $display("FAIL prio_ack5 got=%h/%b exp=80/0", bus.pend_out, bus.valid_out);
      end
      step();
      checks++;
      if (bus.valid_out !== 1'b1 || bus.id_out !== 3'd7) begin
         failures++; $display("FAIL prio_offer7 got=%b/%0d exp=1/7", bus.valid_out, bus.id_out);
      end
      bus.ack_in = 1'b1;
      step();
      bus.ack_in = 1'b0;
      checks++;
      if (bus.pend_out !== 8'h00 || bus.any_out !== 1'b0 || bus.valid_out !== 1'b0) begin
         failures++; $display("FAIL prio_ack7 got=%h/%b/%b exp=00/0/0", bus.pend_out, bus.any_out, bus.valid_out);
      end
      bus.event_in = 8'h00;
      repeat (LAT + 1) step();
   endtask

   task automatic test_mask_during_offer();
      bus.event_in = 8'h08;
      repeat (LAT + 1) step();
      checks++;
      if (bus.valid_out !== 1'b1 || bus.id_out !== 3'd3) begin
         failures++; $display("FAIL mask_offer3 got=%b/%0d exp=1/3", bus.valid_out, bus.id_out);
      end
      bus.mask_in = 8'h00;
      #1;
      checks++;
      if (bus.any_out !== 1'b0) begin failures++; $display("FAIL mask_any_comb got=%b exp=0", bus.any_out); end
      bus.event_in = 8'h48;
      repeat (LAT) step();
      checks++;
      if (bus.pend_out !== 8'h48 || bus.valid_out !== 1'b1 || bus.id_out !== 3'd3) begin
         failures++; $display("FAIL mask_hold got=%h/%b/%0d exp=48/1/3", bus.pend_out, bus.valid_out, bus.id_out);
      end
      bus.ack_in = 1'b1;
      step();
      checks++;
      if (bus.pend_out !== 8'h40 || bus.valid_out !== 1'b0) begin
         failures++; $display("FAIL mask_ack3 got=%h/%b exp=40/0", bus.pend_out, bus.valid_out);
      end
      step();
      bus.ack_in = 1'b0;
      checks++;
      if (bus.pend_out !== 8'h40 || bus.valid_out !== 1'b0) begin
         failures++; $display("FAIL idle_ack_ignored got=%h/%b exp=40/0", bus.pend_out, bus.valid_out);
      end
      bus.mask_in = 8'hFF;
      #1;
      checks++;
      if (bus.any_out !== 1'b1) begin failures++; $display("FAIL unmask_any_comb got=%b exp=1", bus.any_out); end
      step();
      checks++;
      if (bus.valid_out !== 1'b1 || bus.id_out !== 3'd6) begin
         failures++; $display("FAIL mask_offer6 got=%b/%0d exp=1/6", bus.valid_out, bus.id_out);
      end
      bus.ack_in = 1'b1;
      step();
      bus.ack_in = 1'b0;
      bus.event_in = 8'h00;
      checks++;
      if (bus.pend_out !== 8'h00) begin failures++; $display("FAIL mask_final_pend got=%h exp=00", bus.pend_out); end
      repeat (LAT + 1) step();
   endtask

   task automatic test_set_wins();
      bus.event_in = 8'h02;
      repeat (LAT + 1) step();
      checks++;
      if (bus.valid_out !== 1'b1 || bus.id_out !== 3'd1) begin
         failures++; $display("FAIL setwin_offer got=%b/%0d exp=1/1", bus.valid_out, bus.id_out);
      end
      bus.event_in = 8'h00;
      repeat (LAT) step();
      bus.ack_in   = 1'b1;
      bus.event_in = 8'h02;
      step();
      bus.ack_in = 1'b0;
      checks++;
      if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL setwin_drop got=%b exp=0", bus.valid_out); end
      for (int i = 0; i < LAT - 1; i++) step();
      checks++;
      if (bus.pend_out !== 8'h02) begin failures++; $display("FAIL setwin_pend got=%h exp=02", bus.pend_out); end
      step();
      checks++;
      if (bus.valid_out !== 1'b1 || bus.id_out !== 3'd1) begin
         failures++; $display("FAIL setwin_reoffer got=%b/%0d exp=1/1", bus.valid_out, bus.id_out);
      end
      bus.ack_in = 1'b1;
      step();
      bus.ack_in = 1'b0;
      bus.event_in = 8'h00;
      repeat (LAT + 1) step();
   endtask

   task automatic test_reset_held_high();
      bus.event_in = 8'hFF;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (LAT + 3) step();
      checks++;
      if (bus.pend_out !== 8'h00 || bus.valid_out !== 1'b0) begin
         failures++; $display("FAIL held_high_pend got=%h/%b exp=00/0", bus.pend_out, bus.valid_out);
      end
      bus.event_in = 8'hFE;
      repeat (LAT) step();
      bus.event_in = 8'hFF;
      repeat (LAT) step();
      checks++;
      if (bus.pend_out !== 8'h01) begin failures++; $display("FAIL held_high_rearm got=%h exp=01", bus.pend_out); end
      step();
      checks++;
      if (bus.valid_out !== 1'b1 || bus.id_out !== 3'd0) begin
         failures++; $display("FAIL held_high_offer got=%b/%0d exp=1/0", bus.valid_out, bus.id_out);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.valid_out !== 1'b0 || bus.pend_out !== 8'h00) begin
         failures++; $display("FAIL async_reset_offer got=%b/%h exp=0/00", bus.valid_out, bus.pend_out);
      end
      bus.event_in = 8'h00;
      step();
      rst_n = 1'b1;
      repeat (LAT + 1) step();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.event_in = 8'h00;
      bus.mask_in  = 8'hFF;
      bus.ack_in   = 1'b0;
      test_reset();
      test_single();
      test_priority();
      test_mask_during_offer();
      test_set_wins();
      test_reset_held_high();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
